// File: rtl/dense_layer.sv
// Fixed-point fully connected layer: serial over the N inputs, parallel over the M neurons.
// After a start is accepted: N multiply-accumulate cycles, then an output cycle that shifts, saturates and applies the optional ReLU.
module dense_layer #(
   parameter int N    = 4,
   parameter int M    = 4,
   parameter int W    = 16,
   parameter int FRAC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             relu_en,
   input  logic [N*W-1:0]   x,
   input  logic [M*N*W-1:0] w,
   input  logic [M*W-1:0]   b,
   output logic [M*W-1:0]   y,
   output logic             busy,
   output logic             done
);

   localparam int ACC_W = 2*W + $clog2(N+1) + 1;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [N*W-1:0]          x_q, x_d;
   logic [M*N*W-1:0]        w_q, w_d;
   logic                    relu_q, relu_d;
   logic signed [ACC_W-1:0] acc_q [M];
   logic signed [ACC_W-1:0] acc_d [M];
   logic [M*W-1:0]          y_q, y_d;
   logic                    done_q, done_d;

   logic signed [W-1:0]     x_sel;
   logic signed [W-1:0]     w_sel [M];
   logic signed [2*W-1:0]   prod [M];
   logic signed [ACC_W-1:0] shifted [M];
   logic [W-1:0]            result [M];

   // Datapath: the current input times each neuron's weight, and the output-stage conversion
   always_comb begin
      x_sel = x_q[int'(count_q)*W +: W];
      for (int j = 0; j < M; j++) begin
         w_sel[j]   = w_q[(int'(count_q)*M + j)*W +: W];
         prod[j]    = x_sel * w_sel[j];
         shifted[j] = acc_q[j] >>> FRAC;
         if (shifted[j] > SAT_MAX)
            result[j] = SAT_MAX[W-1:0];
         else if (shifted[j] < SAT_MIN)
            result[j] = SAT_MIN[W-1:0];
         else
            result[j] = shifted[j][W-1:0];
         if (relu_q && result[j][W-1])
            result[j] = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      x_d     = x_q;
      w_d     = w_q;
      relu_d  = relu_q;
      acc_d   = acc_q;
      y_d     = y_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = x;
               w_d     = w;
               relu_d  = relu_en;
               count_d = '0;
               for (int j = 0; j < M; j++)
                  acc_d[j] = {{(ACC_W-W){b[j*W+W-1]}}, b[j*W +: W]} <<< FRAC;
               state_d = MAC;
            end
         end
         MAC: begin
            for (int j = 0; j < M; j++)
               acc_d[j] = acc_q[j] + {{(ACC_W-2*W){prod[j][2*W-1]}}, prod[j]};
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(N-1))
               state_d = OUT;
         end
         OUT: begin
            for (int j = 0; j < M; j++)
               y_d[j*W +: W] = result[j];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         x_q     <= '0;
         w_q     <= '0;
         relu_q  <= 1'b0;
         y_q     <= '0;
         done_q  <= 1'b0;
         for (int j = 0; j < M; j++)
            acc_q[j] <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         x_q     <= x_d;
         w_q     <= w_d;
         relu_q  <= relu_d;
         y_q     <= y_d;
         done_q  <= done_d;
         for (int j = 0; j < M; j++)
            acc_q[j] <= acc_d[j];
      end
   end

   assign y    = y_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_dense_layer.sv
// Directed self-checking bench for dense_layer with N=4, M=4, W=16, FRAC=8.
// Expected lane values are worked out by hand from the fixed-point arithmetic.
module tb_dense_layer;

   localparam int N = 4;
   localparam int M = 4;
   localparam int W = 16;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             relu_en;
   logic [N*W-1:0]   x;
   logic [M*N*W-1:0] w;
   logic [M*W-1:0]   b;
   logic [M*W-1:0]   y;
   logic             busy;
   logic             done;

   int n_cmp;
   int n_err;

   dense_layer #(.N(N), .M(M), .W(W), .FRAC(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
      .x(x), .w(w), .b(b), .y(y), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raise start for one rising edge; this returns at the falling edge after the accepting edge
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if (y !== '0) begin n_err++; $display("[TB] FAIL reset_y: got %h expected 0", y); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      x = {N{16'h0100}}; w = {(M*N){16'h0080}}; b = '0; relu_en = 1'b0;
      pulse_start();
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("[TB] FAIL basic_busy_first: got busy=%b done=%b expected busy=1 done=0", busy, done); end
      for (int i = 1; i < N + 1; i++) begin
         @(negedge clk);
         n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("[TB] FAIL basic_busy_%0d: got busy=%b done=%b expected busy=1 done=0", i, busy, done); end
      end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL basic_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
      n_cmp++; if (y !== {M{16'h0200}}) begin n_err++; $display("[TB] FAIL basic_y: got %h expected %h", y, {M{16'h0200}}); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
      n_cmp++; if (y !== {M{16'h0200}}) begin n_err++; $display("[TB] FAIL basic_y_hold: got %h expected %h", y, {M{16'h0200}}); end
   endtask

   task automatic test_neg_relu();
      x = {N{16'h0100}}; w = {(M*N){16'hFF00}}; b = {M{16'h0100}};
      for (int r = 0; r < 2; r++) begin
         relu_en = (r == 1);
         pulse_start();
         repeat (N) @(negedge clk);
         @(negedge clk);
         n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL neg_done_relu%0d: got %b expected 1", r, done); end
         if (r == 0) begin
            n_cmp++; if (y !== {M{16'hFD00}}) begin n_err++; $display("[TB] FAIL neg_identity_y: got %h expected %h", y, {M{16'hFD00}}); end
         end else begin
            n_cmp++; if (y !== {M{16'h0000}}) begin n_err++; $display("[TB] FAIL neg_relu_y: got %h expected 0", y); end
         end
      end
   endtask

   task automatic test_saturation();
      x = {N{16'h7F00}}; w = {(M*N){16'h7F00}}; b = {M{16'h7FFF}}; relu_en = 1'b0;
      pulse_start();
      repeat (N + 1) @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL sat_pos_done: got %b expected 1", done); end
      n_cmp++; if (y !== {M{16'h7FFF}}) begin n_err++; $display("[TB] FAIL sat_pos_y: got %h expected %h", y, {M{16'h7FFF}}); end
      w = {(M*N){16'h8100}};
      pulse_start();
      repeat (N + 1) @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL sat_neg_done: got %b expected 1", done); end
      n_cmp++; if (y !== {M{16'h8000}}) begin n_err++; $display("[TB] FAIL sat_neg_y: got %h expected %h", y, {M{16'h8000}}); end
   endtask

   task automatic test_ignore_start();
      int dones;
      x = {N{16'h0100}}; w = {(M*N){16'h0080}}; b = '0; relu_en = 1'b0;
      pulse_start();
      x = {N{16'h0300}}; relu_en = 1'b1;
      dones = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      if (done === 1'b1) dones++;
      @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL ignore_done: got %b expected 1", done); end
      n_cmp++; if (y !== {M{16'h0200}}) begin n_err++; $display("[TB] FAIL ignore_y: got %h expected %h", y, {M{16'h0200}}); end
      if (done === 1'b1) dones++;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      n_cmp++; if (dones !== 1) begin n_err++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", dones); end
   endtask

   task automatic test_reset_mid();
      int dones;
      x = {N{16'h0100}}; w = {(M*N){16'h0080}}; b = '0; relu_en = 1'b0;
      pulse_start();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (y !== '0) begin n_err++; $display("[TB] FAIL midrst_y: got %h expected 0", y); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_err++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", dones); end
      x = {N{16'h0100}}; w = {(M*N){16'hFF00}}; b = {M{16'h0100}};
      pulse_start();
      repeat (N) @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_early_done: got %b expected 0", done); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_restart_done: got %b expected 1", done); end
      n_cmp++; if (y !== {M{16'hFD00}}) begin n_err++; $display("[TB] FAIL midrst_restart_y: got %h expected %h", y, {M{16'hFD00}}); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      x = {N{16'h0100}}; w = {(M*N){16'h0080}}; b = '0; relu_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      w = {(M*N){16'hFF00}}; b = {M{16'h0100}};
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
      repeat (N) @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_early_done: got %b expected 0", done); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_first_done: got %b expected 1", done); end
      n_cmp++; if (y !== {M{16'h0200}}) begin n_err++; $display("[TB] FAIL b2b_first_y: got %h expected %h", y, {M{16'h0200}}); end
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_second_busy: got busy=%b done=%b expected busy=1 done=0", busy, done); end
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         n_cmp++; if (done !== 1'b0 || y !== {M{16'h0200}}) begin n_err++; $display("[TB] FAIL b2b_hold_%0d: got done=%b y=%h expected done=0 y=%h", i, done, y, {M{16'h0200}}); end
      end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_second_done: got %b expected 1", done); end
      n_cmp++; if (y !== {M{16'hFD00}}) begin n_err++; $display("[TB] FAIL b2b_second_y: got %h expected %h", y, {M{16'hFD00}}); end
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      relu_en = 1'b0;
      x       = '0;
      w       = '0;
      b       = '0;
      test_reset();
      test_basic();
      test_neg_relu();
      test_saturation();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
